// File: rtl/risc_xunit.sv
// risc_xunit -- execution unit for a small RISC datapath.
//
// Accepts one operation per cycle through a valid/ready handshake and
// presents the registered result one cycle later. Single-cycle ALU, shift,
// rotate and load/store-pass-through ops run at full rate; MUL runs a
// shift-add sequence over DW cycles while in_rdy is held low.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   in_vld / in_rdy   operation handshake; accept when both are high
//   opcode            5-bit operation code
//   oprnd_a, oprnd_b  DW-bit operands
//   dstin, dmaddrin   destination register / data-memory address
//   out_vld           one-cycle pulse per completed operation
//   rslt, dmdatain    result (dmdatain mirrors rslt for stores)
//   dst, dmaddr       destination register / memory address of the result
//   reg_wr_vld        register-file write enable
//   dmenbl, rdwr      memory enable, read(1)/write(0)
//   load_op           result must be replaced by memory read data
//   flags             {Z, N, C, V}
module risc_xunit #(
    parameter int DW = 8,
    parameter int AW = 4,
    parameter int RW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_vld,
    output logic          in_rdy,
    input  logic [4:0]    opcode,
    input  logic [DW-1:0] oprnd_a,
    input  logic [DW-1:0] oprnd_b,
    input  logic [RW-1:0] dstin,
    input  logic [AW-1:0] dmaddrin,
    output logic          out_vld,
    output logic [DW-1:0] rslt,
    output logic [RW-1:0] dst,
    output logic [AW-1:0] dmaddr,
    output logic [DW-1:0] dmdatain,
    output logic          reg_wr_vld,
    output logic          dmenbl,
    output logic          rdwr,
    output logic          load_op,
    output logic [3:0]    flags
);

    localparam logic [4:0] OP_ADD = 5'h01, OP_SUB = 5'h02, OP_AND = 5'h03,
                           OP_OR  = 5'h04, OP_XOR = 5'h05, OP_INC = 5'h06,
                           OP_DEC = 5'h07, OP_NOT = 5'h08, OP_NEG = 5'h09,
                           OP_SHR = 5'h0A, OP_SHL = 5'h0B, OP_ROR = 5'h0C,
                           OP_ROL = 5'h0D, OP_LD  = 5'h0E, OP_ST  = 5'h0F,
                           OP_MUL = 5'h10, OP_ADC = 5'h11, OP_SBB = 5'h12,
                           OP_CMP = 5'h13;

    localparam int CW = $clog2(DW + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(DW);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DONE = 2'd2} state_t;

    // Returns {overflow, carry, sum} of x + y + ci.
    function automatic logic [DW+1:0] adder(input logic [DW-1:0] x,
                                            input logic [DW-1:0] y,
                                            input logic          ci);
        logic [DW:0] s;
        logic        v;
        s = {1'b0, x} + {1'b0, y} + {{DW{1'b0}}, ci};
        v = (x[DW-1] == y[DW-1]) && (s[DW-1] != x[DW-1]);
        return {v, s};
    endfunction

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*DW-1:0] acc_q, acc_d, mcand_q, mcand_d, acc_step_s;
    logic [DW-1:0]   mplier_q, mplier_d;
    logic [DW-1:0]   rslt_q, rslt_d;
    logic [RW-1:0]   dst_q, dst_d;
    logic [AW-1:0]   dmaddr_q, dmaddr_d;
    logic [3:0]      flags_q, flags_d;
    logic            out_vld_q, out_vld_d, reg_wr_vld_q, reg_wr_vld_d;
    logic            dmenbl_q, dmenbl_d, rdwr_q, rdwr_d, load_op_q, load_op_d;

    logic            in_rdy_s, accept_s;
    logic [DW-1:0]   add_x_s, add_y_s, res_s, zn_src_s;
    logic            add_ci_s, upd_zn_s, upd_cv_s, c_new_s, v_new_s;
    logic            wr_s, dmen_s, rdwr_s, ld_s;
    logic [DW+1:0]   add_out_s;

    // Operand selection for the shared adder; subtracts feed ~b.
    always_comb begin
        add_x_s  = oprnd_a;
        add_y_s  = oprnd_b;
        add_ci_s = 1'b0;
        case (opcode)
            OP_SUB, OP_CMP: begin add_y_s = ~oprnd_b; add_ci_s = 1'b1;       end
            OP_ADC:         begin add_ci_s = flags_q[1];                     end
            OP_SBB:         begin add_y_s = ~oprnd_b; add_ci_s = flags_q[1]; end
            OP_INC:         begin add_y_s = {DW{1'b0}}; add_ci_s = 1'b1;     end
            OP_DEC:         begin add_y_s = {DW{1'b1}};                      end
            OP_NEG:         begin add_x_s = ~oprnd_a; add_y_s = {DW{1'b0}}; add_ci_s = 1'b1; end
            default:        begin add_ci_s = 1'b0;                           end
        endcase
        add_out_s = adder(add_x_s, add_y_s, add_ci_s);
    end

    // Single-cycle result, flag updates and write-back controls per opcode.
    always_comb begin
        res_s    = rslt_q;
        zn_src_s = rslt_q;
        upd_zn_s = 1'b0;
        upd_cv_s = 1'b0;
        c_new_s  = flags_q[1];
        v_new_s  = 1'b0;
        wr_s     = 1'b0;
        dmen_s   = 1'b0;
        rdwr_s   = 1'b1;
        ld_s     = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_ADC, OP_SBB, OP_INC, OP_DEC, OP_NEG: begin
                res_s = add_out_s[DW-1:0]; zn_src_s = res_s;
                upd_zn_s = 1'b1; upd_cv_s = 1'b1; wr_s = 1'b1;
                c_new_s = add_out_s[DW]; v_new_s = add_out_s[DW+1];
            end
            OP_CMP: begin
                // flags from the difference, result register untouched
                zn_src_s = add_out_s[DW-1:0];
                upd_zn_s = 1'b1; upd_cv_s = 1'b1;
                c_new_s = add_out_s[DW]; v_new_s = add_out_s[DW+1];
            end
            OP_AND: begin res_s = oprnd_a & oprnd_b; zn_src_s = res_s; upd_zn_s = 1'b1; wr_s = 1'b1; end
            OP_OR:  begin res_s = oprnd_a | oprnd_b; zn_src_s = res_s; upd_zn_s = 1'b1; wr_s = 1'b1; end
            OP_XOR: begin res_s = oprnd_a ^ oprnd_b; zn_src_s = res_s; upd_zn_s = 1'b1; wr_s = 1'b1; end
            OP_NOT: begin res_s = ~oprnd_a;          zn_src_s = res_s; upd_zn_s = 1'b1; wr_s = 1'b1; end
            OP_ROR: begin res_s = {oprnd_a[0], oprnd_a[DW-1:1]}; zn_src_s = res_s; upd_zn_s = 1'b1; wr_s = 1'b1; end
            OP_ROL: begin res_s = {oprnd_a[DW-2:0], oprnd_a[DW-1]}; zn_src_s = res_s; upd_zn_s = 1'b1; wr_s = 1'b1; end
            OP_SHR: begin
                res_s = {1'b0, oprnd_a[DW-1:1]}; zn_src_s = res_s;
                upd_zn_s = 1'b1; upd_cv_s = 1'b1; wr_s = 1'b1; c_new_s = oprnd_a[0];
            end
            OP_SHL: begin
                res_s = {oprnd_a[DW-2:0], 1'b0}; zn_src_s = res_s;
                upd_zn_s = 1'b1; upd_cv_s = 1'b1; wr_s = 1'b1; c_new_s = oprnd_a[DW-1];
            end
            OP_LD:  begin res_s = oprnd_a; wr_s = 1'b1; dmen_s = 1'b1; ld_s = 1'b1; end
            OP_ST:  begin res_s = oprnd_a; dmen_s = 1'b1; rdwr_s = 1'b0; end
            default: begin res_s = rslt_q; end
        endcase
    end

    assign in_rdy_s   = (state_q != S_MUL);
    assign accept_s   = in_vld && in_rdy_s;
    assign acc_step_s = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    // Next-state and registered-output logic; MUL sequencing lives here.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        rslt_d       = rslt_q;
        dst_d        = dst_q;
        dmaddr_d     = dmaddr_q;
        flags_d      = flags_q;
        out_vld_d    = 1'b0;
        reg_wr_vld_d = 1'b0;
        dmenbl_d     = 1'b0;
        rdwr_d       = 1'b1;
        load_op_d    = 1'b0;
        case (state_q)
            S_MUL: begin
                acc_d    = acc_step_s;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CNT_ONE;
                // last shift-add: publish the product on this same edge
                if (cnt_q == CNT_ONE) begin
                    state_d      = S_DONE;
                    out_vld_d    = 1'b1;
                    reg_wr_vld_d = 1'b1;
                    rslt_d       = acc_step_s[DW-1:0];
                    flags_d      = {(acc_step_s[DW-1:0] == {DW{1'b0}}), acc_step_s[DW-1],
                                    (acc_step_s[2*DW-1:DW] != {DW{1'b0}}), 1'b0};
                end else begin
                    state_d = S_MUL;
                end
            end
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept_s) begin
                    dst_d    = dstin;
                    dmaddr_d = dmaddrin;
                    if (opcode == OP_MUL) begin
                        state_d  = S_MUL;
                        cnt_d    = CNT_LOAD;
                        acc_d    = {(2*DW){1'b0}};
                        mcand_d  = {{DW{1'b0}}, oprnd_a};
                        mplier_d = oprnd_b;
                    end else begin
                        out_vld_d    = 1'b1;
                        reg_wr_vld_d = wr_s;
                        dmenbl_d     = dmen_s;
                        rdwr_d       = rdwr_s;
                        load_op_d    = ld_s;
                        rslt_d       = res_s;
                        flags_d      = {upd_zn_s ? (zn_src_s == {DW{1'b0}}) : flags_q[3],
                                        upd_zn_s ? zn_src_s[DW-1] : flags_q[2],
                                        upd_cv_s ? c_new_s : flags_q[1],
                                        upd_cv_s ? v_new_s : flags_q[0]};
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= {CW{1'b0}};
            acc_q        <= {(2*DW){1'b0}};
            mcand_q      <= {(2*DW){1'b0}};
            mplier_q     <= {DW{1'b0}};
            rslt_q       <= {DW{1'b0}};
            dst_q        <= {RW{1'b0}};
            dmaddr_q     <= {AW{1'b0}};
            flags_q      <= 4'b0000;
            out_vld_q    <= 1'b0;
            reg_wr_vld_q <= 1'b0;
            dmenbl_q     <= 1'b0;
            rdwr_q       <= 1'b1;
            load_op_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            mcand_q      <= mcand_d;
            mplier_q     <= mplier_d;
            rslt_q       <= rslt_d;
            dst_q        <= dst_d;
            dmaddr_q     <= dmaddr_d;
            flags_q      <= flags_d;
            out_vld_q    <= out_vld_d;
            reg_wr_vld_q <= reg_wr_vld_d;
            dmenbl_q     <= dmenbl_d;
            rdwr_q       <= rdwr_d;
            load_op_q    <= load_op_d;
        end
    end

    assign in_rdy     = in_rdy_s;
    assign out_vld    = out_vld_q;
    assign rslt       = rslt_q;
    assign dmdatain   = rslt_q;
    assign dst        = dst_q;
    assign dmaddr     = dmaddr_q;
    assign flags      = flags_q;
    assign reg_wr_vld = reg_wr_vld_q;
    assign dmenbl     = dmenbl_q;
    assign rdwr       = rdwr_q;
    assign load_op    = load_op_q;

endmodule

// File: tb/tb_risc_xunit.sv
// Self-checking bench for risc_xunit (DW=8, AW=4, RW=3).
// A behavioural model tracks the expected outputs using plain integer
// arithmetic; a negedge process compares every output every cycle, and the
// directed sequence pins key results with hand-computed literals.
module tb_risc_xunit;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int RW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_vld = 1'b0;
    logic          in_rdy;
    logic [4:0]    opcode = 5'd0;
    logic [DW-1:0] oprnd_a = 8'd0;
    logic [DW-1:0] oprnd_b = 8'd0;
    logic [RW-1:0] dstin = 3'd0;
    logic [AW-1:0] dmaddrin = 4'd0;
    logic          out_vld, reg_wr_vld, dmenbl, rdwr, load_op;
    logic [DW-1:0] rslt, dmdatain;
    logic [RW-1:0] dst;
    logic [AW-1:0] dmaddr;
    logic [3:0]    flags;

    int checks = 0;
    int errors = 0;

    risc_xunit #(.DW(DW), .AW(AW), .RW(RW)) dut (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy),
        .opcode(opcode), .oprnd_a(oprnd_a), .oprnd_b(oprnd_b),
        .dstin(dstin), .dmaddrin(dmaddrin), .out_vld(out_vld), .rslt(rslt),
        .dst(dst), .dmaddr(dmaddr), .dmdatain(dmdatain),
        .reg_wr_vld(reg_wr_vld), .dmenbl(dmenbl), .rdwr(rdwr),
        .load_op(load_op), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_rslt = 8'h00;
    logic [2:0] m_dst = 3'd0;
    logic [3:0] m_addr = 4'd0;
    logic m_z = 1'b0, m_n = 1'b0, m_c = 1'b0, m_v = 1'b0;
    logic m_vld = 1'b0, m_wr = 1'b0, m_dmen = 1'b0, m_rdwr = 1'b1, m_ld = 1'b0, m_rdy = 1'b1;
    int   m_busy = 0;
    int   m_pa = 0, m_pb = 0;

    function automatic int sgn(input int x);
        return (x > 127) ? x - 256 : x;
    endfunction

    task automatic model_exec(input int op, input int a, input int b);
        int s, sd, r;
        bit is_add, zn, wr;
        s = 0; sd = 0; r = m_rslt; is_add = 0;
        zn = (op >= 1 && op <= 13) || op == 17 || op == 18 || op == 19;
        wr = (op >= 1 && op <= 14) || op == 17 || op == 18;
        m_vld = 1'b1;
        case (op)
            1:       begin s = a + b;             sd = sgn(a) + sgn(b);                 is_add = 1; end
            2, 19:   begin s = a + (255 - b) + 1; sd = sgn(a) - sgn(b);                 is_add = 1; end
            17:      begin s = a + b + int'(m_c); sd = sgn(a) + sgn(b) + int'(m_c);     is_add = 1; end
            18:      begin s = a + (255 - b) + int'(m_c); sd = sgn(a) - sgn(b) - (1 - int'(m_c)); is_add = 1; end
            6:       begin s = a + 1;             sd = sgn(a) + 1;                      is_add = 1; end
            7:       begin s = a + 255;           sd = sgn(a) - 1;                      is_add = 1; end
            9:       begin s = (255 - a) + 1;     sd = -sgn(a);                         is_add = 1; end
            3:       r = a & b;
            4:       r = a | b;
            5:       r = a ^ b;
            8:       r = 255 - a;
            10:      begin r = a >> 1;          m_c = (a % 2) == 1; m_v = 1'b0; end
            11:      begin r = (a * 2) % 256;   m_c = a > 127;      m_v = 1'b0; end
            12:      r = (a / 2) + (a % 2) * 128;
            13:      r = (a * 2) % 256 + a / 128;
            14:      begin r = a; m_dmen = 1'b1; m_ld = 1'b1; end
            15:      begin r = a; m_dmen = 1'b1; m_rdwr = 1'b0; end
            default: r = m_rslt;
        endcase
        if (is_add) begin
            r   = s % 256;
            m_c = s > 255;
            m_v = (sd > 127) || (sd < -128);
        end
        if (zn) begin
            m_z = (r == 0);
            m_n = (r > 127);
        end
        m_wr = wr;
        if (op != 19) m_rslt = 8'(r);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rslt = 8'h00; m_dst = 3'd0; m_addr = 4'd0;
            {m_z, m_n, m_c, m_v} = 4'b0000;
            m_vld = 1'b0; m_wr = 1'b0; m_dmen = 1'b0; m_rdwr = 1'b1; m_ld = 1'b0;
            m_busy = 0; m_rdy = 1'b1;
        end else begin
            m_vld = 1'b0; m_wr = 1'b0; m_dmen = 1'b0; m_rdwr = 1'b1; m_ld = 1'b0;
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    int p;
                    p = m_pa * m_pb;
                    m_rslt = 8'(p % 256);
                    m_z = (p % 256) == 0;
                    m_n = (p % 256) > 127;
                    m_c = (p / 256) != 0;
                    m_v = 1'b0;
                    m_vld = 1'b1; m_wr = 1'b1;
                end
            end else if (in_vld) begin
                m_dst = dstin;
                m_addr = dmaddrin;
                if (opcode == 5'h10) begin
                    m_busy = 8; m_pa = int'(oprnd_a); m_pb = int'(oprnd_b);
                end else begin
                    model_exec(int'(opcode), int'(oprnd_a), int'(oprnd_b));
                end
            end
            m_rdy = (m_busy == 0);
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("out_vld", 32'(out_vld), 32'(m_vld));
        chk("in_rdy", 32'(in_rdy), 32'(m_rdy));
        chk("rslt", 32'(rslt), 32'(m_rslt));
        chk("dmdatain", 32'(dmdatain), 32'(m_rslt));
        chk("dst", 32'(dst), 32'(m_dst));
        chk("dmaddr", 32'(dmaddr), 32'(m_addr));
        chk("flags", 32'(flags), 32'({m_z, m_n, m_c, m_v}));
        chk("reg_wr_vld", 32'(reg_wr_vld), 32'(m_wr));
        chk("dmenbl", 32'(dmenbl), 32'(m_dmen));
        chk("rdwr", 32'(rdwr), 32'(m_rdwr));
        chk("load_op", 32'(load_op), 32'(m_ld));
    end

    // ---------------- directed stimulus ----------------
    task automatic issue(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] d, input logic [3:0] ad);
        in_vld = 1'b1; opcode = op; oprnd_a = a; oprnd_b = b; dstin = d; dmaddrin = ad;
        @(posedge clk); #1;
        in_vld = 1'b0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 1;
        while (out_vld !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    localparam int NV = 18;
    logic [4:0] tv_op [NV] = '{5'h02, 5'h12, 5'h06, 5'h09, 5'h09, 5'h08, 5'h03, 5'h04,
                              5'h0A, 5'h0B, 5'h0C, 5'h0D, 5'h00, 5'h14, 5'h1F, 5'h11,
                              5'h02, 5'h12};
    logic [7:0] tv_a [NV]  = '{8'h10, 8'h50, 8'h7F, 8'h80, 8'h00, 8'h0F, 8'hF0, 8'h0F,
                              8'h81, 8'h81, 8'h01, 8'h80, 8'h12, 8'h34, 8'h56, 8'hFF,
                              8'h80, 8'h00};
    logic [7:0] tv_b [NV]  = '{8'h20, 8'h30, 8'h00, 8'h00, 8'h00, 8'h00, 8'h3C, 8'hA0,
                              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                              8'h01, 8'h01};

    initial begin
        int cyc, low, seen;
        // reset state, with the first op already offered
        #20;
        in_vld = 1'b1; opcode = 5'h01; oprnd_a = 8'hFF; oprnd_b = 8'h01; dstin = 3'd3; dmaddrin = 4'd2;
        chk("rst_rslt", 32'(rslt), 32'h0);
        chk("rst_flags", 32'(flags), 32'h0);
        chk("rst_in_rdy", 32'(in_rdy), 32'h1);
        chk("rst_rdwr", 32'(rdwr), 32'h1);
        chk("rst_out_vld", 32'(out_vld), 32'h0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        in_vld = 1'b0;
        // ADD FF+01 accepted on first edge after release
        chk("add_ff_rslt", 32'(rslt), 32'h00);
        chk("add_ff_flags", 32'(flags), 32'hA);
        chk("add_ff_wr", 32'(reg_wr_vld), 32'h1);
        chk("add_ff_dst", 32'(dst), 32'h3);

        // back-to-back ADD then ADC
        issue(5'h01, 8'h7F, 8'h01, 3'd1, 4'd0);
        chk("add_7f_rslt", 32'(rslt), 32'h80);
        chk("add_7f_flags", 32'(flags), 32'h5);
        issue(5'h11, 8'h00, 8'h00, 3'd2, 4'd0);
        chk("adc_rslt", 32'(rslt), 32'h00);
        chk("adc_flags", 32'(flags), 32'h8);
        // idle cycle
        @(posedge clk); #1;
        chk("idle_out_vld", 32'(out_vld), 32'h0);
        chk("idle_wr", 32'(reg_wr_vld), 32'h0);
        chk("idle_rslt", 32'(rslt), 32'h00);

        // MUL 0D*0B with an ADD held on the input during the busy period
        issue(5'h10, 8'h0D, 8'h0B, 3'd5, 4'd1);
        in_vld = 1'b1; opcode = 5'h01; oprnd_a = 8'h01; oprnd_b = 8'h01; dstin = 3'd6; dmaddrin = 4'd0;
        cyc = 1; low = 0;
        while (out_vld !== 1'b1 && cyc < 20) begin
            if (in_rdy === 1'b0) low++;
            @(posedge clk); #1;
            cyc++;
        end
        chk("mul_latency", 32'(cyc), 32'd9);
        chk("mul_rdy_low", 32'(low), 32'd8);
        chk("mul_rslt", 32'(rslt), 32'h8F);
        chk("mul_flags", 32'(flags), 32'h4);
        chk("mul_dst", 32'(dst), 32'h5);
        chk("mul_done_rdy", 32'(in_rdy), 32'h1);
        @(posedge clk); #1;
        in_vld = 1'b0;
        chk("done_accept_rslt", 32'(rslt), 32'h02);
        chk("done_accept_vld", 32'(out_vld), 32'h1);

        // MUL 10*10 overflows into the high half
        issue(5'h10, 8'h10, 8'h10, 3'd7, 4'd0);
        wait_out(cyc);
        chk("mul2_latency", 32'(cyc), 32'd9);
        chk("mul2_rslt", 32'(rslt), 32'h00);
        chk("mul2_flags", 32'(flags), 32'hA);

        // CMP leaves rslt alone
        issue(5'h05, 8'h5A, 8'h00, 3'd1, 4'd0);
        issue(5'h13, 8'h05, 8'h05, 3'd2, 4'd0);
        chk("cmp_rslt", 32'(rslt), 32'h5A);
        chk("cmp_flags", 32'(flags), 32'hA);
        chk("cmp_wr", 32'(reg_wr_vld), 32'h0);
        chk("cmp_vld", 32'(out_vld), 32'h1);

        // store and load
        issue(5'h0F, 8'h3C, 8'h00, 3'd0, 4'h9);
        chk("st_dmenbl", 32'(dmenbl), 32'h1);
        chk("st_rdwr", 32'(rdwr), 32'h0);
        chk("st_dmaddr", 32'(dmaddr), 32'h9);
        chk("st_data", 32'(dmdatain), 32'h3C);
        chk("st_wr", 32'(reg_wr_vld), 32'h0);
        issue(5'h0E, 8'h77, 8'h00, 3'd4, 4'h3);
        chk("ld_load_op", 32'(load_op), 32'h1);
        chk("ld_wr", 32'(reg_wr_vld), 32'h1);

        // DEC 00 borrows
        issue(5'h07, 8'h00, 8'h00, 3'd1, 4'd0);
        chk("dec_rslt", 32'(rslt), 32'hFF);
        chk("dec_flags", 32'(flags), 32'h4);

        // remaining ops, model-checked, with a gap every fourth op
        for (int i = 0; i < NV; i++) begin
            issue(tv_op[i], tv_a[i], tv_b[i], 3'(i), 4'(i));
            if (tv_op[i] == 5'h0A) chk("shr_81_rslt", 32'(rslt), 32'h40);
            if (i % 4 == 3) begin
                @(posedge clk); #1;
            end
        end

        // reset in the middle of a multiply
        issue(5'h10, 8'h0D, 8'h0B, 3'd4, 4'd5);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_out_vld", 32'(out_vld), 32'h0);
        chk("mrst_rslt", 32'(rslt), 32'h0);
        chk("mrst_flags", 32'(flags), 32'h0);
        chk("mrst_in_rdy", 32'(in_rdy), 32'h1);
        chk("mrst_rdwr", 32'(rdwr), 32'h1);
        chk("mrst_dst", 32'(dst), 32'h0);
        chk("mrst_dmenbl", 32'(dmenbl), 32'h0);
        @(posedge clk); #3 rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_vld === 1'b1) seen++;
        end
        chk("mrst_no_out_vld", 32'(seen), 32'd0);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
